// File: rtl/serial_frame_tx.sv
// Serial frame transmitter: start bit, DATA_W data bits LSB first, optional even
// parity bit, one stop bit. Each bit is held for BAUD_DIV clock cycles.
module serial_frame_tx #(
  parameter int DATA_W    = 8,
  parameter int BAUD_DIV  = 4,
  parameter int PARITY_EN = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tx_valid,
  input  logic [DATA_W-1:0] tx_data,
  output logic              tx_ready,
  output logic              tx_out,
  output logic              busy
);

  localparam int BW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t              state_q, state_d;
  logic [BW-1:0]       baud_q, baud_d;
  logic [CW-1:0]       bit_q, bit_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic                par_q, par_d;
  logic                tx_out_q, tx_out_d;
  logic                tx_ready_q, tx_ready_d;
  logic                busy_q, busy_d;
  logic                baud_wrap;

  assign baud_wrap = (baud_q == BW'(BAUD_DIV - 1));

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;

    unique case (state_q)
      S_IDLE: begin
        if (tx_valid && tx_ready_q) begin
          state_d = S_START;
          shift_d = tx_data;
          // Parity is captured up front because the shift register is consumed by the data phase.
          par_d   = ^tx_data;
          baud_d  = '0;
          bit_d   = '0;
        end
      end
      S_START: begin
        if (baud_wrap) begin
          baud_d  = '0;
          state_d = S_DATA;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      S_DATA: begin
        if (baud_wrap) begin
          baud_d  = '0;
          shift_d = shift_q >> 1;
          if (bit_q == CW'(DATA_W - 1)) begin
            bit_d   = '0;
            state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
          end else begin
            bit_d = bit_q + CW'(1);
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      S_PARITY: begin
        if (baud_wrap) begin
          baud_d  = '0;
          state_d = S_STOP;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      S_STOP: begin
        if (baud_wrap) begin
          baud_d  = '0;
          state_d = S_IDLE;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        baud_d  = '0;
        bit_d   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they change on the same edge as the state.
  always_comb begin
    tx_out_d   = 1'b1;
    tx_ready_d = (state_d == S_IDLE);
    busy_d     = (state_d != S_IDLE);
    unique case (state_d)
      S_IDLE:   tx_out_d = 1'b1;
      S_START:  tx_out_d = 1'b0;
      S_DATA:   tx_out_d = shift_d[0];
      S_PARITY: tx_out_d = par_d;
      S_STOP:   tx_out_d = 1'b1;
      default:  tx_out_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      baud_q     <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      tx_out_q   <= 1'b1;
      tx_ready_q <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      tx_out_q   <= tx_out_d;
      tx_ready_q <= tx_ready_d;
      busy_q     <= busy_d;
    end
  end

  assign tx_out   = tx_out_q;
  assign tx_ready = tx_ready_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_serial_frame_tx.sv
// Bench for serial_frame_tx: three configurations (defaults, parity on, one cycle per bit)
// checked every cycle against a frame-waveform model plus directed literal frames.
module tb_serial_frame_tx;

  logic       clk;
  logic       reset;
  logic [2:0] vld;
  logic [7:0] dat [3];
  logic [2:0] out;
  logic [2:0] rdy;
  logic [2:0] bsy;

  int total = 0;
  int bad   = 0;

  // Model: after an accept the line follows a precomputed waveform, one entry per cycle.
  logic m_wave [3][64];
  int   m_len  [3];
  int   m_k    [3];
  bit   m_busy [3];

  serial_frame_tx u0 (
    .clk(clk), .reset(reset), .tx_valid(vld[0]), .tx_data(dat[0]),
    .tx_ready(rdy[0]), .tx_out(out[0]), .busy(bsy[0])
  );
  serial_frame_tx #(.PARITY_EN(1)) u1 (
    .clk(clk), .reset(reset), .tx_valid(vld[1]), .tx_data(dat[1]),
    .tx_ready(rdy[1]), .tx_out(out[1]), .busy(bsy[1])
  );
  serial_frame_tx #(.BAUD_DIV(1)) u2 (
    .clk(clk), .reset(reset), .tx_valid(vld[2]), .tx_data(dat[2]),
    .tx_ready(rdy[2]), .tx_out(out[2]), .busy(bsy[2])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int bd_of(input int i);
    return (i == 2) ? 1 : 4;
  endfunction

  function automatic bit pen_of(input int i);
    return (i == 1);
  endfunction

  task automatic check(input string nm, input int i, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s inst=%0d got=%b want=%b t=%0t", nm, i, act, exp, $time);
    end
  endtask

  task automatic model_load(input int i, input logic [7:0] d);
    int bits[$];
    bits.push_back(0);
    for (int b = 0; b < 8; b++) bits.push_back(int'(d[b]));
    if (pen_of(i)) bits.push_back(int'(^d));
    bits.push_back(1);
    m_len[i] = 0;
    foreach (bits[j]) begin
      for (int r = 0; r < bd_of(i); r++) begin
        m_wave[i][m_len[i]] = bits[j][0];
        m_len[i]++;
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      m_busy[i] = 0;
      m_k[i]    = 0;
      m_len[i]  = 0;
    end
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) begin
        for (int i = 0; i < 3; i++) begin
          m_busy[i] = 0;
          m_k[i]    = 0;
        end
      end else if (clk) begin
        for (int i = 0; i < 3; i++) begin
          if (m_busy[i]) begin
            m_k[i]++;
            if (m_k[i] == m_len[i]) m_busy[i] = 0;
          end else if (vld[i]) begin
            model_load(i, dat[i]);
            m_busy[i] = 1;
            m_k[i]    = 0;
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        check("cyc_out",   i, out[i], m_busy[i] ? m_wave[i][m_k[i]] : 1'b1);
        check("cyc_ready", i, rdy[i], !m_busy[i]);
        check("cyc_busy",  i, bsy[i], m_busy[i]);
      end
    end
  end

  // Sends one word and checks each bit at its first cycle, plus frame length.
  task automatic frame_check(input int i, input logic [7:0] d, input int nb,
                             input logic [15:0] exp_bits, input int pulse_k);
    int bd;
    int len;
    bd  = bd_of(i);
    len = nb * bd;
    vld[i] = 1'b1;
    dat[i] = d;
    @(posedge clk);
    @(negedge clk);
    vld[i] = 1'b0;
    dat[i] = ~d;
    for (int k = 0; k <= len; k++) begin
      if (k == pulse_k) begin
        vld[i] = 1'b1;
        dat[i] = 8'hFF;
      end
      if (k == pulse_k + 1) begin
        vld[i] = 1'b0;
        dat[i] = 8'h55;
      end
      if (k < len && (k % bd) == 0) begin
        check("frame_bit", i, out[i], exp_bits[k / bd]);
        check("model_bit", i, m_wave[i][k], exp_bits[k / bd]);
      end
      if (k == len - 1) check("ready_low_end", i, rdy[i], 1'b0);
      if (k == len)     check("ready_back",    i, rdy[i], 1'b1);
      if (k < len) @(negedge clk);
    end
  endtask

  initial begin
    logic [9:0] e1;
    logic [9:0] e2;
    int         guard;
    reset = 1'b0;
    vld   = 3'b111;
    for (int i = 0; i < 3; i++) dat[i] = 8'hA5;

    // Reset held with tx_valid asserted: idle outputs, no accept.
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        check("rst_out",   i, out[i], 1'b1);
        check("rst_ready", i, rdy[i], 1'b1);
        check("rst_busy",  i, bsy[i], 1'b0);
      end
    end
    vld = 3'b000;
    #1 reset = 1'b1;
    @(negedge clk);
    @(negedge clk);

    // Single frames.
    frame_check(0, 8'hA5, 10, {6'd0, 1'b1, 8'hA5, 1'b0}, -5);
    frame_check(1, 8'h07, 11, {5'd0, 1'b1, 1'b1, 8'h07, 1'b0}, -5);
    frame_check(1, 8'h03, 11, {5'd0, 1'b1, 1'b0, 8'h03, 1'b0}, -5);
    // Busy ignore: 8'hFF pulsed mid-frame of 8'h00.
    frame_check(0, 8'h00, 10, {6'd0, 1'b1, 8'h00, 1'b0}, 14);
    @(negedge clk);
    @(negedge clk);
    check("ignored_idle_out",  0, out[0], 1'b1);
    check("ignored_idle_busy", 0, bsy[0], 1'b0);

    // Back-to-back with tx_valid held high.
    e1 = {1'b1, 8'h3C, 1'b0};
    e2 = {1'b1, 8'hC3, 1'b0};
    vld[0] = 1'b1;
    dat[0] = 8'h3C;
    @(posedge clk);
    @(negedge clk);
    dat[0] = 8'hC3;
    for (int k = 0; k <= 81; k++) begin
      if (k < 40 && (k % 4) == 0) check("b2b_first", 0, out[0], e1[k / 4]);
      if (k == 40) begin
        check("b2b_gap_out",   0, out[0], 1'b1);
        check("b2b_gap_ready", 0, rdy[0], 1'b1);
      end
      if (k == 41) begin
        check("b2b_second_start", 0, out[0], 1'b0);
        check("b2b_second_ready", 0, rdy[0], 1'b0);
        vld[0] = 1'b0;
      end
      if (k >= 41 && k < 81 && ((k - 41) % 4) == 0) check("b2b_second", 0, out[0], e2[(k - 41) / 4]);
      if (k == 81) check("b2b_end_ready", 0, rdy[0], 1'b1);
      if (k < 81) @(negedge clk);
    end

    // Reset mid-frame during data bit 3 of 8'h5A, asserted between edges.
    vld[0] = 1'b1;
    dat[0] = 8'h5A;
    @(posedge clk);
    @(negedge clk);
    vld[0] = 1'b0;
    repeat (17) @(negedge clk);
    check("pre_abort_busy", 0, bsy[0], 1'b1);
    check("pre_abort_bit3", 0, out[0], 1'b1);
    #1 reset = 1'b0;
    #1;
    check("abort_out",   0, out[0], 1'b1);
    check("abort_ready", 0, rdy[0], 1'b1);
    check("abort_busy",  0, bsy[0], 1'b0);
    @(negedge clk);
    #2 reset = 1'b1;
    @(negedge clk);
    frame_check(0, 8'h81, 10, {6'd0, 1'b1, 8'h81, 1'b0}, -5);
    frame_check(2, 8'h81, 10, {6'd0, 1'b1, 8'h81, 1'b0}, -5);

    // Randomized traffic on all three instances, with rare asynchronous resets.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        vld[i] = ($urandom_range(0, 3) == 0);
        dat[i] = 8'($urandom);
      end
      if ($urandom_range(0, 599) == 0) begin
        #1 reset = 1'b0;
        #3 reset = 1'b1;
      end
    end
    @(negedge clk);
    vld = 3'b000;
    guard = 0;
    while (!(rdy == 3'b111 && !m_busy[0] && !m_busy[1] && !m_busy[2]) && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check("drain_timeout", 0, (guard < 200), 1'b1);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
